// File: rtl/chip8_pkg.sv
// Shared CHIP-8 memory-system constants and types.
//   ADDR_W/DATA_W : RAM address/data widths
//   FONT_TOP      : first writable address (font glyphs live below it)
//   LOCK_MAX_DEF  : default bound on consecutive locked draw grants
//   req_id_t      : requester identity, used for the grant and the read-return tag
//   rr_ptr_t      : CPU/draw round-robin pointer
package chip8_pkg;

    localparam int unsigned ADDR_W       = 12;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned FONT_TOP     = 512;
    localparam int unsigned LOCK_MAX_DEF = 16;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_LD   = 2'd1,
        REQ_CPU  = 2'd2,
        REQ_DRW  = 2'd3
    } req_id_t;

    typedef enum logic {
        RR_CPU = 1'b0,
        RR_DRW = 1'b1
    } rr_ptr_t;

    // True when an address falls inside the read-only font region.
    function automatic logic is_protected(input logic [ADDR_W-1:0] addr);
        return addr < ADDR_W'(FONT_TOP);
    endfunction

endpackage

// File: rtl/rr_lock_sel.sv
// CPU / draw-engine winner selection: round-robin with a bounded draw burst lock.
//   clk, rst   : clock, async active-high reset
//   cpu_req    : CPU requesting
//   drw_req    : draw engine requesting
//   drw_lock   : draw engine asks for burst ownership
//   blocked    : a higher-priority source owns the RAM this cycle (no grant, no state change)
//   cpu_win_c  : CPU wins this cycle (combinational)
//   drw_win_c  : draw engine wins this cycle (combinational)
module rr_lock_sel
    import chip8_pkg::*;
#(
    parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic drw_req,
    input  logic drw_lock,
    input  logic blocked,
    output logic cpu_win_c,
    output logic drw_win_c
);

    localparam int unsigned RUN_W = $clog2(LOCK_MAX + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_MAX);

    rr_ptr_t          ptr_q,   ptr_nxt;
    logic             lock_q,  lock_nxt;
    logic             yield_q, yield_nxt;
    logic [RUN_W-1:0] run_q,   run_nxt;
    logic [RUN_W-1:0] run_inc;
    logic             lock_live;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= RR_CPU;
            lock_q  <= 1'b0;
            yield_q <= 1'b0;
            run_q   <= '0;
        end else begin
            ptr_q   <= ptr_nxt;
            lock_q  <= lock_nxt;
            yield_q <= yield_nxt;
            run_q   <= run_nxt;
        end
    end

    // Winner selection and next-state.
    always_comb begin
        ptr_nxt   = ptr_q;
        lock_nxt  = lock_q;
        yield_nxt = yield_q;
        run_nxt   = run_q;
        cpu_win_c = 1'b0;
        drw_win_c = 1'b0;
        run_inc   = '0;

        // Ownership lapses the moment the draw engine drops req or lock.
        lock_live = lock_q & drw_req & drw_lock;

        if (!blocked) begin
            if (yield_q && cpu_req) begin
                cpu_win_c = 1'b1;
            end else if (lock_live) begin
                drw_win_c = 1'b1;
            end else if (cpu_req && drw_req) begin
                cpu_win_c = (ptr_q == RR_CPU);
                drw_win_c = (ptr_q == RR_DRW);
            end else begin
                cpu_win_c = cpu_req;
                drw_win_c = drw_req;
            end
        end

        if (!lock_live && lock_q) begin
            lock_nxt = 1'b0;
            run_nxt  = '0;
        end

        if (cpu_win_c) begin
            ptr_nxt   = RR_DRW;
            yield_nxt = 1'b0;
        end

        if (drw_win_c) begin
            ptr_nxt   = RR_CPU;
            yield_nxt = 1'b0;
            if (drw_lock) begin
                // Fresh engagement restarts the run; an existing one counts up, saturating.
                if (!lock_q) begin
                    run_inc = RUN_W'(1);
                end else if (run_q == RUN_MAX) begin
                    run_inc = run_q;
                end else begin
                    run_inc = run_q + RUN_W'(1);
                end
                if (run_inc >= RUN_MAX) begin
                    lock_nxt  = 1'b0;
                    yield_nxt = 1'b1;
                    run_nxt   = RUN_MAX;
                end else begin
                    lock_nxt  = 1'b1;
                    run_nxt   = run_inc;
                end
            end else begin
                lock_nxt = 1'b0;
                run_nxt  = '0;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port CHIP-8 RAM access controller for loader, CPU and draw engine.
//   clk, rst                            : clock, async active-high reset
//   ld_req/ld_addr/ld_din -> ld_ack     : loader writes, highest priority
//   cpu_req/cpu_we/cpu_addr/cpu_din     : CPU read/write; cpu_ack, cpu_rvalid/cpu_rdata
//   drw_req/drw_lock/drw_addr           : draw reads with optional burst lock; drw_ack, drw_rvalid/drw_rdata
//   ram_addr/ram_din/ram_we, ram_dout   : RAM port (1-cycle registered read)
//   wp_err                              : pulse the cycle after a suppressed font-region write
module ram_arbiter
    import chip8_pkg::*;
#(
    parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_din,
    output logic              ld_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic              cpu_ack,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              drw_req,
    input  logic              drw_lock,
    input  logic [ADDR_W-1:0] drw_addr,
    output logic              drw_ack,
    output logic              drw_rvalid,
    output logic [DATA_W-1:0] drw_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              wp_err
);

    req_id_t grant_c;
    req_id_t tag_q;
    logic    cpu_win_c;
    logic    drw_win_c;
    logic    wr_c;
    logic    wp_hit_c;

    // Loader and reset both pre-empt the CPU/draw selection.
    rr_lock_sel #(
        .LOCK_MAX (LOCK_MAX)
    ) u_sel (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .drw_req   (drw_req),
        .drw_lock  (drw_lock),
        .blocked   (rst | ld_req),
        .cpu_win_c (cpu_win_c),
        .drw_win_c (drw_win_c)
    );

    // Grant resolution and RAM port mux.
    always_comb begin
        grant_c  = REQ_NONE;
        ram_addr = '0;
        ram_din  = '0;
        wr_c     = 1'b0;
        if (!rst) begin
            if (ld_req) begin
                grant_c = REQ_LD;
            end else if (cpu_win_c) begin
                grant_c = REQ_CPU;
            end else if (drw_win_c) begin
                grant_c = REQ_DRW;
            end
        end
        case (grant_c)
            REQ_LD: begin
                ram_addr = ld_addr;
                ram_din  = ld_din;
                wr_c     = 1'b1;
            end
            REQ_CPU: begin
                ram_addr = cpu_addr;
                ram_din  = cpu_din;
                wr_c     = cpu_we;
            end
            REQ_DRW: begin
                ram_addr = drw_addr;
            end
            default: ;
        endcase
    end

    // Font-region writes are acked but never reach the RAM.
    assign wp_hit_c = wr_c & is_protected(ram_addr);
    assign ram_we   = wr_c & ~wp_hit_c;

    assign ld_ack  = (grant_c == REQ_LD);
    assign cpu_ack = (grant_c == REQ_CPU);
    assign drw_ack = (grant_c == REQ_DRW);

    // Read-return tag and write-protect pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q  <= REQ_NONE;
            wp_err <= 1'b0;
        end else begin
            wp_err <= wp_hit_c;
            if (grant_c == REQ_CPU && !cpu_we) begin
                tag_q <= REQ_CPU;
            end else if (grant_c == REQ_DRW) begin
                tag_q <= REQ_DRW;
            end else begin
                tag_q <= REQ_NONE;
            end
        end
    end

    assign cpu_rvalid = (tag_q == REQ_CPU);
    assign drw_rvalid = (tag_q == REQ_DRW);
    assign cpu_rdata  = ram_dout;
    assign drw_rdata  = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter (LOCK_MAX = 4) with a behavioural sync RAM.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_req;
    logic [11:0] ld_addr;
    logic [7:0]  ld_din;
    logic        ld_ack;
    logic        cpu_req;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_ack;
    logic        cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic        drw_req;
    logic        drw_lock;
    logic [11:0] drw_addr;
    logic        drw_ack;
    logic        drw_rvalid;
    logic [7:0]  drw_rdata;
    logic [11:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [7:0]  ram_dout;
    logic        wp_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [4096];

    ram_arbiter #(.LOCK_MAX(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_req     (ld_req),
        .ld_addr    (ld_addr),
        .ld_din     (ld_din),
        .ld_ack     (ld_ack),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_ack    (cpu_ack),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .drw_req    (drw_req),
        .drw_lock   (drw_lock),
        .drw_addr   (drw_addr),
        .drw_ack    (drw_ack),
        .drw_rvalid (drw_rvalid),
        .drw_rdata  (drw_rdata),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .ram_dout   (ram_dout),
        .wp_err     (wp_err)
    );

    always #5 clk = ~clk;

    // Single-port RAM, registered read.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ld_req = 0; ld_addr = '0; ld_din = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
        drw_req = 0; drw_lock = 0; drw_addr = '0;
    endtask

    task automatic test_reset();
        rst = 1;
        ld_req = 1; ld_addr = 12'h300; ld_din = 8'h11;
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h050;
        drw_req = 1; drw_lock = 1; drw_addr = 12'h051;
        step(); step();
        checks++; if ({ld_ack, cpu_ack, drw_ack} !== 3'b000) begin errors++; $display("FAIL reset_acks: got %b expected 000", {ld_ack, cpu_ack, drw_ack}); end
        checks++; if ({cpu_rvalid, drw_rvalid, wp_err, ram_we} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {cpu_rvalid, drw_rvalid, wp_err, ram_we}); end
        checks++; if (ram_addr !== 12'h000 || ram_din !== 8'h00) begin errors++; $display("FAIL reset_bus: got %h/%h expected 000/00", ram_addr, ram_din); end
        rst = 0; ld_req = 0; drw_lock = 0;
        #1;
        checks++; if ({cpu_ack, drw_ack} !== 2'b10) begin errors++; $display("FAIL reset_first_cpu: got %b expected 10", {cpu_ack, drw_ack}); end
        step();
        idle();
    endtask

    task automatic test_load_then_read();
        ld_req = 1; ld_addr = 12'h200; ld_din = 8'hA5;
        #1;
        checks++; if (ld_ack !== 1'b1 || ram_we !== 1'b1) begin errors++; $display("FAIL ld_write: got ack=%b we=%b expected 1/1", ld_ack, ram_we); end
        step();
        idle(); cpu_req = 1; cpu_addr = 12'h200;
        #1;
        checks++; if (cpu_ack !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL cpu_read_ack: got ack=%b we=%b expected 1/0", cpu_ack, ram_we); end
        step();
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'hA5) begin errors++; $display("FAIL cpu_read_data: got %b/%h expected 1/a5", cpu_rvalid, cpu_rdata); end
        checks++; if (drw_rvalid !== 1'b0) begin errors++; $display("FAIL cpu_read_no_drw: got %b expected 0", drw_rvalid); end
        idle();
        #1;
        checks++; if (ram_addr !== 12'h000 || ram_we !== 1'b0) begin errors++; $display("FAIL idle_bus: got %h/%b expected 000/0", ram_addr, ram_we); end
        step();
    endtask

    // Last grant was CPU, so the pointer favours the draw engine first.
    task automatic test_round_robin();
        logic exp_d;
        cpu_req = 1; cpu_addr = 12'h200;
        drw_req = 1; drw_addr = 12'h050;
        for (int i = 0; i < 6; i++) begin
            exp_d = (i % 2 == 0);
            #1;
            checks++; if ({cpu_ack, drw_ack} !== {~exp_d, exp_d}) begin errors++; $display("FAIL rr_ack[%0d]: got %b expected %b", i, {cpu_ack, drw_ack}, {~exp_d, exp_d}); end
            checks++; if (ram_addr !== (exp_d ? 12'h050 : 12'h200)) begin errors++; $display("FAIL rr_addr[%0d]: got %h", i, ram_addr); end
            step();
            if (exp_d) begin
                checks++; if ({cpu_rvalid, drw_rvalid} !== 2'b01 || drw_rdata !== 8'hF0) begin errors++; $display("FAIL rr_ret[%0d]: got %b/%h expected 01/f0", i, {cpu_rvalid, drw_rvalid}, drw_rdata); end
            end else begin
                checks++; if ({cpu_rvalid, drw_rvalid} !== 2'b10 || cpu_rdata !== 8'hA5) begin errors++; $display("FAIL rr_ret[%0d]: got %b/%h expected 10/a5", i, {cpu_rvalid, drw_rvalid}, cpu_rdata); end
            end
        end
        idle();
    endtask

    task automatic test_write_protect();
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'h050; cpu_din = 8'h33;
        #1;
        checks++; if (cpu_ack !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL wp_font_write: got ack=%b we=%b expected 1/0", cpu_ack, ram_we); end
        step();
        checks++; if (wp_err !== 1'b1 || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL wp_err_pulse: got err=%b rvalid=%b expected 1/0", wp_err, cpu_rvalid); end
        cpu_we = 0;
        #1;
        step();
        checks++; if (wp_err !== 1'b0) begin errors++; $display("FAIL wp_err_clear: got %b expected 0", wp_err); end
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'hF0) begin errors++; $display("FAIL wp_font_kept: got %b/%h expected 1/f0", cpu_rvalid, cpu_rdata); end
        idle(); ld_req = 1; ld_addr = 12'h1FF; ld_din = 8'h77;
        #1;
        checks++; if (ld_ack !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL wp_ld_1ff: got ack=%b we=%b expected 1/0", ld_ack, ram_we); end
        step();
        checks++; if (wp_err !== 1'b1) begin errors++; $display("FAIL wp_ld_err: got %b expected 1", wp_err); end
        idle(); cpu_req = 1; cpu_we = 1; cpu_addr = 12'h200; cpu_din = 8'h5C;
        #1;
        checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL wp_boundary_200: got we=%b expected 1", ram_we); end
        step();
        checks++; if (wp_err !== 1'b0) begin errors++; $display("FAIL wp_boundary_err: got %b expected 0", wp_err); end
        cpu_we = 0;
        #1;
        step();
        checks++; if (cpu_rdata !== 8'h5C) begin errors++; $display("FAIL raw_same_addr: got %h expected 5c", cpu_rdata); end
        idle();
    endtask

    // Cycles 0-4 CPU idle: the yield after the 4th grant goes unused, draw keeps going.
    // From cycle 5 the CPU requests and gets the slot after each run of 4 locked grants.
    task automatic test_lock_yield();
        logic [13:0] exp_pat;
        exp_pat = 14'b01111011111111;
        drw_req = 1; drw_lock = 1; drw_addr = 12'h051;
        cpu_addr = 12'h200;
        for (int i = 0; i < 14; i++) begin
            cpu_req = (i >= 5);
            #1;
            checks++; if ({cpu_ack, drw_ack} !== {~exp_pat[i], exp_pat[i]}) begin errors++; $display("FAIL lock_ack[%0d]: got %b expected %b", i, {cpu_ack, drw_ack}, {~exp_pat[i], exp_pat[i]}); end
            step();
        end
        idle();
    endtask

    task automatic test_all_three_and_reset();
        drw_req = 1; drw_lock = 1; drw_addr = 12'h052;
        #1;
        step();
        ld_req = 1; ld_addr = 12'h300; ld_din = 8'h42;
        cpu_req = 1; cpu_addr = 12'h200;
        #1;
        checks++; if ({ld_ack, cpu_ack, drw_ack} !== 3'b100) begin errors++; $display("FAIL three_ld_wins: got %b expected 100", {ld_ack, cpu_ack, drw_ack}); end
        step();
        ld_req = 0;
        #1;
        checks++; if ({cpu_ack, drw_ack} !== 2'b01) begin errors++; $display("FAIL three_lock_holds: got %b expected 01", {cpu_ack, drw_ack}); end
        step();
        rst = 1;
        #1;
        checks++; if (drw_rvalid !== 1'b0) begin errors++; $display("FAIL rst_drop_rvalid: got %b expected 0", drw_rvalid); end
        step();
        rst = 0;
        #1;
        checks++; if ({cpu_ack, drw_ack} !== 2'b10) begin errors++; $display("FAIL rst_cpu_first: got %b expected 10", {cpu_ack, drw_ack}); end
        step();
        checks++; if (cpu_rvalid !== 1'b1 || drw_rvalid !== 1'b0) begin errors++; $display("FAIL rst_post_read: got %b%b expected 10", cpu_rvalid, drw_rvalid); end
        idle();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h050] = 8'hF0;
        mem[12'h051] = 8'h90;
        mem[12'h052] = 8'hE0;
        idle();
        rst = 1;
        test_reset();
        test_load_then_read();
        test_round_robin();
        test_write_protect();
        test_lock_yield();
        test_all_three_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
